// File: rtl/hit_detector.sv
// Player/enemy collision detector. It registers at most one hit pulse per frame, then runs a
// frame-counted invulnerability window with a blink enable for the heart sprite.
module hit_detector #(
    parameter int unsigned H_LAST        = 799,
    parameter int unsigned V_LAST        = 524,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BATTLE_STATE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       player_on,
    input  logic       enemy_on,
    output logic       collision,
    output logic       invuln,
    output logic       blink,
    output logic [7:0] hit_count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam logic [9:0] H_LAST_C   = 10'(H_LAST);
    localparam logic [9:0] V_LAST_C   = 10'(V_LAST);
    localparam logic [7:0] INVULN_C   = 8'(INVULN_FRAMES);
    localparam logic [1:0] BATTLE_C   = 2'(BATTLE_STATE);
    localparam logic [7:0] HIT_MAX    = 8'hFF;

    logic [1:0] fsm_q, fsm_d;
    logic       frame_hit_q, frame_hit_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic       collision_q, collision_d;
    logic       invuln_q, invuln_d;
    logic       blink_q, blink_d;
    logic       eof_raw_q;

    logic eof_raw;
    logic eof;
    logic in_battle;
    logic ovl;
    logic frame_any;

    // The last pixel may be held for several clks when the pixel clock is slower than clk,
    // so only the first clk of it counts as the frame end.
    assign eof_raw   = (x == H_LAST_C) && (y == V_LAST_C);
    assign eof       = eof_raw && !eof_raw_q;
    assign in_battle = (state == BATTLE_C);
    assign ovl       = player_on && enemy_on && (fsm_q == ST_ARMED);
    assign frame_any = frame_hit_q || ovl;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        fsm_d       = fsm_q;
        frame_hit_d = frame_hit_q;
        inv_cnt_d   = inv_cnt_q;
        hit_count_d = hit_count_q;
        collision_d = 1'b0;

        if (!in_battle) begin
            fsm_d       = ST_IDLE;
            frame_hit_d = 1'b0;
            inv_cnt_d   = 8'd0;
            hit_count_d = 8'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    fsm_d = ST_ARMED;
                end

                ST_ARMED: begin
                    if (eof) begin
                        frame_hit_d = 1'b0;
                        if (frame_any) begin
                            collision_d = 1'b1;
                            if (hit_count_q != HIT_MAX) begin
                                hit_count_d = hit_count_q + 8'd1;
                            end
                            if (INVULN_C != 8'd0) begin
                                inv_cnt_d = INVULN_C;
                                fsm_d     = ST_COOLDOWN;
                            end
                        end
                    end else begin
                        frame_hit_d = frame_any;
                    end
                end

                ST_COOLDOWN: begin
                    frame_hit_d = 1'b0;
                    if (eof) begin
                        // Saturating decrement: a zero count can never wrap to 255.
                        if (inv_cnt_q > 8'd1) begin
                            inv_cnt_d = inv_cnt_q - 8'd1;
                        end else begin
                            inv_cnt_d = 8'd0;
                            fsm_d     = ST_ARMED;
                        end
                    end
                end

                default: begin
                    fsm_d       = ST_IDLE;
                    frame_hit_d = 1'b0;
                    inv_cnt_d   = 8'd0;
                end
            endcase
        end

        invuln_d = (fsm_d == ST_COOLDOWN);
        blink_d  = invuln_d && inv_cnt_d[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            frame_hit_q <= 1'b0;
            inv_cnt_q   <= 8'd0;
            hit_count_q <= 8'd0;
            collision_q <= 1'b0;
            invuln_q    <= 1'b0;
            blink_q     <= 1'b0;
            eof_raw_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fsm_q       <= fsm_d;
            frame_hit_q <= frame_hit_d;
            inv_cnt_q   <= inv_cnt_d;
            hit_count_q <= hit_count_d;
            collision_q <= collision_d;
            invuln_q    <= invuln_d;
            blink_q     <= blink_d;
            eof_raw_q   <= eof_raw;
        end
    end

    assign collision = collision_q;
    assign invuln    = invuln_q;
    assign blink     = blink_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_hit_detector.sv
// Self-checking bench for hit_detector: two instances (60-frame and zero invulnerability) on a
// shrunken raster, checked every clk against a frame-level behavioural model.
module tb_hit_detector;

    localparam int H_LAST = 7;
    localparam int V_LAST = 5;
    localparam int FRAME  = (H_LAST + 1) * (V_LAST + 1);
    localparam int BATTLE = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] st_i;
    logic [9:0] x_i;
    logic [9:0] y_i;
    logic       p_i;
    logic       e_i;

    logic       coll1, inv1, blink1;
    logic [7:0] hc1;
    logic       coll0, inv0, blink0;
    logic [7:0] hc0;

    hit_detector #(
        .H_LAST(H_LAST), .V_LAST(V_LAST), .INVULN_FRAMES(60), .BATTLE_STATE(BATTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(st_i), .x(x_i), .y(y_i),
        .player_on(p_i), .enemy_on(e_i),
        .collision(coll1), .invuln(inv1), .blink(blink1), .hit_count(hc1)
    );

    hit_detector #(
        .H_LAST(H_LAST), .V_LAST(V_LAST), .INVULN_FRAMES(0), .BATTLE_STATE(BATTLE)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .state(st_i), .x(x_i), .y(y_i),
        .player_on(p_i), .enemy_on(e_i),
        .collision(coll0), .invuln(inv0), .blink(blink0), .hit_count(hc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level view of the game rules: whether we are in battle, frames of invulnerability
    // left, whether this frame already saw an overlap, and the hit tally.
    typedef struct {
        logic active;
        logic cooling;
        int   remaining;
        logic seen;
        int   hits;
        logic coll;
        logic prev_raw;
    } model_t;

    model_t m1, m0;
    int checks   = 0;
    int failures = 0;
    int pulses1, pulses0, pulse_idx;
    logic last_inv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t step(input model_t m, input int inv,
                                    input logic [9:0] xx, input logic [9:0] yy,
                                    input logic p, input logic e, input logic [1:0] st);
        logic raw, eof, hit;
        raw    = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
        eof    = raw && !m.prev_raw;
        m.coll = 1'b0;
        if (st != 2'(BATTLE)) begin
            m.active = 0; m.cooling = 0; m.remaining = 0; m.seen = 0; m.hits = 0;
        end else if (!m.active) begin
            m.active = 1;
        end else if (m.cooling) begin
            if (eof) begin
                m.remaining = m.remaining - 1;
                if (m.remaining == 0) m.cooling = 0;
            end
        end else begin
            hit = m.seen || (p && e);
            if (eof) begin
                m.seen = 0;
                if (hit) begin
                    m.coll = 1;
                    if (m.hits < 255) m.hits = m.hits + 1;
                    if (inv > 0) begin
                        m.cooling   = 1;
                        m.remaining = inv;
                    end
                end
            end else begin
                m.seen = hit;
            end
        end
        m.prev_raw = raw;
        return m;
    endfunction

    function automatic logic exp_blink(input model_t m);
        return m.cooling && ((m.remaining / 4) % 2 == 1);
    endfunction

    task automatic compare_outputs();
        check("collision",   32'(coll1),  32'(m1.coll));
        check("invuln",      32'(inv1),   32'(m1.cooling));
        check("blink",       32'(blink1), 32'(exp_blink(m1)));
        check("hit_count",   32'(hc1),    32'(m1.hits));
        check("collision0",  32'(coll0),  32'(m0.coll));
        check("invuln0",     32'(inv0),   32'(m0.cooling));
        check("blink0",      32'(blink0), 32'(exp_blink(m0)));
        check("hit_count0",  32'(hc0),    32'(m0.hits));
    endtask

    task automatic cycle();
        m1 = step(m1, 60, x_i, y_i, p_i, e_i, st_i);
        m0 = step(m0, 0,  x_i, y_i, p_i, e_i, st_i);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coll"},  32'({coll1, coll0}),   32'd0);
        check({tag, "_inv"},   32'({inv1, inv0}),     32'd0);
        check({tag, "_blink"}, 32'({blink1, blink0}), 32'd0);
        check({tag, "_hc"},    32'({hc1, hc0}),       32'd0);
    endtask

    // mode: 0 none, 1 every pixel, 2 single pixel (3,2), 3 only the last pixel, 4 random
    task automatic run_pixels(input int mode, input int first, input int count);
        pulses1   = 0;
        pulses0   = 0;
        pulse_idx = -1;
        for (int i = first; i < first + count; i++) begin
            x_i  = 10'(i % (H_LAST + 1));
            y_i  = 10'(i / (H_LAST + 1));
            st_i = 2'(BATTLE);
            case (mode)
                1:       begin p_i = 1'b1; e_i = 1'b1; end
                2:       begin p_i = (x_i == 10'd3) && (y_i == 10'd2); e_i = p_i; end
                3:       begin p_i = (i == FRAME - 1); e_i = p_i; end
                4: begin
                    p_i = ($urandom_range(0, 7) == 0);
                    e_i = ($urandom_range(0, 7) == 0);
                    if ($urandom_range(0, 299) == 0) st_i = 2'($urandom_range(0, 3));
                end
                default: begin p_i = 1'b0; e_i = 1'b0; end
            endcase
            if (i == FRAME - 1) last_inv = inv1;
            cycle();
            if (coll1) begin
                pulses1++;
                pulse_idx = i;
            end
            if (coll0) pulses0++;
        end
    endtask

    task automatic run_frame(input int mode);
        run_pixels(mode, 0, FRAME);
    endtask

    task automatic hold(input int n, input logic [1:0] st);
        x_i = 10'd0; y_i = 10'd0; p_i = 1'b0; e_i = 1'b0; st_i = st;
        repeat (n) cycle();
    endtask

    initial begin
        int pulse_frames[$];
        int inv_eofs;
        int total0;

        rst_n = 1'b0;
        st_i  = 2'(BATTLE);
        x_i   = 10'd0; y_i = 10'd0; p_i = 1'b0; e_i = 1'b0;
        m1    = '{default: 0};
        m0    = '{default: 0};

        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single overlapping pixel: one pulse right after the frame-end edge.
        run_frame(2);
        check("a_pulses",    32'(pulses1),   32'd1);
        check("a_pulse_idx", 32'(pulse_idx), 32'(FRAME - 1));
        check("a_hit_count", 32'(hc1),       32'd1);
        check("a_invuln",    32'(inv1),      32'd1);

        // Leaving battle mid-cooldown clears everything on that clk.
        hold(1, 2'd0);
        check("d_invuln",    32'(inv1), 32'd0);
        check("d_hit_count", 32'(hc1),  32'd0);
        run_frame(2);
        check("d_pulses",    32'(pulses1), 32'd1);

        // Continuous overlap for 70 frames with a 60-frame window.
        hold(2, 2'd0);
        inv_eofs = 0;
        for (int f = 1; f <= 70; f++) begin
            run_frame(1);
            if (pulses1 != 0) pulse_frames.push_back(f);
            if (f <= 62 && last_inv) inv_eofs++;
        end
        check("b_pulse_cnt", 32'(pulse_frames.size()), 32'd2);
        if (pulse_frames.size() == 2) begin
            check("b_first",  32'(pulse_frames[0]), 32'd1);
            check("b_second", 32'(pulse_frames[1]), 32'd62);
        end
        check("b_inv_eofs", 32'(inv_eofs), 32'd60);

        // Overlap only on the frame-end pixel, then hold that coordinate.
        hold(2, 2'd0);
        run_frame(3);
        x_i = 10'(H_LAST); y_i = 10'(V_LAST); p_i = 1'b0; e_i = 1'b0;
        repeat (10) begin
            cycle();
            if (coll1) pulses1++;
            if (coll0) pulses0++;
        end
        check("c_pulses",  32'(pulses1), 32'd1);
        check("c_pulses0", 32'(pulses0), 32'd1);

        // Zero-window instance: a pulse every frame and a saturating counter.
        hold(2, 2'd0);
        total0 = 0;
        repeat (300) begin
            run_frame(1);
            total0 += pulses0;
        end
        check("e_pulses0",    32'(total0), 32'd300);
        check("e_hit_count0", 32'(hc0),    32'd255);
        check("e_invuln0",    32'(inv0),   32'd0);

        // Random overlap density and occasional state drops.
        repeat (40) begin
            if ($urandom_range(0, 7) == 0) hold($urandom_range(1, 3), 2'd0);
            run_frame(4);
        end

        // Asynchronous reset mid-frame with hits and a pending overlap.
        hold(2, 2'd0);
        run_frame(2);
        run_pixels(2, 0, 30);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("async_hold");
        @(negedge clk);
        rst_n = 1'b1;
        m1 = '{default: 0};
        m0 = '{default: 0};
        run_pixels(0, 30, FRAME - 30);
        check("g_pulses",  32'(pulses1), 32'd0);
        check("g_pulses0", 32'(pulses0), 32'd0);
        run_frame(2);
        check("g_rehit",   32'(pulses1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
